demorgan_stim_checker: RTL and testbench
========================================

Name: demorgan_stim_checker

Overview:
Self-checking stimulus/response stage wrapped around the combinational De Morgan gate (inputs a, b; output e).
- Upstream role: drives a and b through every 2-bit input vector, holding each vector for a programmable settle time.
- Downstream role: samples e and compares it against the golden ~(a|b), the first De Morgan form.
- Counts mismatches, records the first failing vector, and reports pass/done, so the gate can be checked on the board without a simulator.

Parameters:
HOLD_CYCLES, 5, clock cycles each vector is driven before e is sampled (legal range >= 1).
PASSES, 4, number of full 4-vector sweeps per run (legal range >= 1).
ERR_W, 8, width of the saturating mismatch counter.

Ports:
clk  input  1  system clock; one clock domain.
rst_n  input  1  reset; one clock; reset is asynchronous and active-low.
start  input  1  run request; sampled only in IDLE or DONE.
e_in  input  1  gate output e under test.
a  output  1  stimulus to gate input a; a = vec_idx[1].
b  output  1  stimulus to gate input b; b = vec_idx[0].
busy  output  1  high while in DRIVE or SAMPLE.
done  output  1  high in DONE; held until the next start or reset.
pass  output  1  done && (err_count == 0).
err_count  output  ERR_W  saturating count of mismatches.
vec_idx  output  2  index of the vector currently being driven.
first_fail_valid  output  1  set on the first mismatch of a run.
first_fail_vec  output  2  vector index of the first mismatch; valid when first_fail_valid is high.

Behaviour:
- Reset (async assert, sync release): state=IDLE; a, b, busy, done, pass, err_count, vec_idx, first_fail_valid and first_fail_vec are all 0; internal counters are 0.
- Reset mid-run: all outputs and counters return immediately to their reset values; no partial results are kept.
- FSM states: IDLE, DRIVE, SAMPLE, DONE.
- IDLE, start=1 at edge T0:
  - go to DRIVE; vec_idx=0, a=b=0.
  - clear err_count, first_fail_valid and first_fail_vec; load pass counter = PASSES.
- DRIVE: hold counter counts from 0 to HOLD_CYCLES-1 with a/b stable, then go to SAMPLE.
- SAMPLE (exactly one cycle):
  - compare e_in against expected = ~(a|b).
  - on a mismatch, err_count increments and saturates at 2^ERR_W-1.
  - on the first mismatch of the run, also first_fail_valid=1 and first_fail_vec=vec_idx.
  - vec_idx advances mod 4 and a/b update on the same edge.
  - if vec_idx was 3, decrement the pass counter; when it reaches 0 go to DONE, otherwise go to DRIVE.
- Cycle budget:
  - each vector occupies exactly HOLD_CYCLES+1 cycles.
  - done rises at edge T0 + PASSES*4*(HOLD_CYCLES+1); with defaults that is T0+96.
- DONE:
  - a/b held at 0, vec_idx=0, busy=0, done=1; pass reflects err_count.
  - start=1 restarts exactly as from IDLE; done drops on that edge.
- start while busy: ignored, no effect on the sequence.
- start held high continuously: the run restarts on the edge after DONE is entered; done is high for exactly one cycle.
- e_in is treated as synchronous to clk; no synchronizer in this block.

Decomposition:
Shared package (demorgan_pkg) holds:
- the state enum {IDLE, DRIVE, SAMPLE, DONE};
- the constant NUM_VEC=4;
- the golden function expected_e(a,b) = ~(a|b), reused by the testbench scoreboard.

One natural sub-module, demorgan_hold_timer:
- a loadable down-counter of width $clog2(HOLD_CYCLES+1) with a terminal-count output driving the DRIVE->SAMPLE transition.

Test Plan:
- Power-up and reset: rst_n low, then high, no start -> all outputs 0, state IDLE, a=b=0.
- Golden gate (e_in = ~(a|b)), defaults, start pulsed at T0 -> done=1 at T0+96, err_count=0, pass=1, first_fail_valid=0.
- Faulty gate e_in=~(a&b) (wrong De Morgan form) -> mismatch on vectors 01 and 10 in every pass; err_count=8, first_fail_vec=2'b01, pass=0.
- Saturation: ERR_W=2, e_in stuck at 1 -> 3 mismatches/pass * 4 passes = 12 raw; err_count saturates at 3, first_fail_vec=2'b01.
- Reset mid-run: golden gate, rst_n low at T0+40 -> all outputs 0 in the same cycle; after release, start again -> done at new T0+96, pass=1.
- Control races: start pulsed at T0+10 while busy -> ignored, done still at T0+96; start held high -> done is a single-cycle pulse and a second run completes 96 cycles later.

Source files
------------

// File: rtl/demorgan_pkg.sv
// Shared types and the golden De Morgan reference
// for the gate stimulus/response checker.
package demorgan_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DRIVE,
        SAMPLE,
        DONE
    } state_t;

    localparam int NUM_VEC = 4;

    function automatic logic expected_e(input logic a, input logic b);
        return ~(a | b);
    endfunction

endpackage

// File: rtl/demorgan_hold_timer.sv
// Loadable down-counter that paces how long each
// stimulus vector is held before it is sampled.
module demorgan_hold_timer #(
    parameter int HOLD_CYCLES = 5
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic en,
    output logic tc
);

    localparam int CW = $clog2(HOLD_CYCLES + 1);
    localparam logic [CW-1:0] LOAD_VAL = CW'(HOLD_CYCLES - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= LOAD_VAL;
        end else if (en && cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign tc = (cnt == '0);

endmodule

// File: rtl/demorgan_stim_checker.sv
// Sweeps all input vectors into the gate under test and
// scores its output against the golden ~(a|b) form.
module demorgan_stim_checker
    import demorgan_pkg::*;
#(
    parameter int HOLD_CYCLES = 5,
    parameter int PASSES      = 4,
    parameter int ERR_W       = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             e_in,
    output logic             a,
    output logic             b,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic [1:0]       vec_idx,
    output logic             first_fail_valid,
    output logic [1:0]       first_fail_vec
);

    localparam int PC_W = $clog2(PASSES + 1);
    localparam logic [ERR_W-1:0] ERR_MAX = '1;
    localparam logic [1:0] LAST_VEC = 2'(NUM_VEC - 1);

    state_t          state;
    logic [PC_W-1:0] pass_cnt;
    logic            launch;
    logic            mismatch;
    logic            last_vec;
    logic            last_pass;
    logic            tmr_load;
    logic            tmr_tc;
    logic [1:0]      vec_next;
    logic [ERR_W-1:0] err_next;

    always_comb begin
        launch    = start && (state == IDLE || state == DONE);
        mismatch  = (state == SAMPLE) && (e_in != expected_e(a, b));
        last_vec  = (vec_idx == LAST_VEC);
        last_pass = (pass_cnt == PC_W'(1));
        tmr_load  = launch || (state == SAMPLE);
        vec_next  = vec_idx + 1'b1;
        err_next  = err_count;
        if (mismatch && err_count != ERR_MAX) begin
            err_next = err_count + 1'b1;
        end
    end

    demorgan_hold_timer #(
        .HOLD_CYCLES(HOLD_CYCLES)
    ) u_timer (
        .clk  (clk),
        .rst_n(rst_n),
        .load (tmr_load),
        .en   (state == DRIVE),
        .tc   (tmr_tc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= IDLE;
            pass_cnt         <= '0;
            a                <= 1'b0;
            b                <= 1'b0;
            busy             <= 1'b0;
            done             <= 1'b0;
            pass             <= 1'b0;
            err_count        <= '0;
            vec_idx          <= '0;
            first_fail_valid <= 1'b0;
            first_fail_vec   <= '0;
        end else begin
            unique case (state)
                IDLE, DONE: begin
                    if (launch) begin
                        state            <= DRIVE;
                        pass_cnt         <= PC_W'(PASSES);
                        a                <= 1'b0;
                        b                <= 1'b0;
                        busy             <= 1'b1;
                        done             <= 1'b0;
                        pass             <= 1'b0;
                        err_count        <= '0;
                        vec_idx          <= '0;
                        first_fail_valid <= 1'b0;
                        first_fail_vec   <= '0;
                    end
                end
                DRIVE: begin
                    if (tmr_tc) begin
                        state <= SAMPLE;
                    end
                end
                SAMPLE: begin
                    err_count <= err_next;
                    if (mismatch && !first_fail_valid) begin
                        first_fail_valid <= 1'b1;
                        first_fail_vec   <= vec_idx;
                    end
                    // Wrap from 3 lands on vector 0, so DONE sees a=b=0.
                    vec_idx <= vec_next;
                    a       <= vec_next[1];
                    b       <= vec_next[0];
                    state   <= DRIVE;
                    if (last_vec) begin
                        pass_cnt <= pass_cnt - 1'b1;
                        if (last_pass) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            pass  <= (err_next == '0);
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_demorgan_stim_checker.sv
// Self-checking bench: table cases, random gate faults
// against a sweep-level model, and control corner cases.
module tb_demorgan_stim_checker;
    import demorgan_pkg::*;

    localparam int H    = 5;
    localparam int P    = 4;
    localparam int W    = 8;
    localparam int LAT  = P * NUM_VEC * (H + 1);
    localparam int SH   = 1;
    localparam int SW   = 2;
    localparam int SLAT = P * NUM_VEC * (SH + 1);

    logic clk = 1'b0;
    logic rst_n;
    logic start;
    logic e_m;
    logic a;
    logic b;
    logic busy;
    logic done;
    logic pass;
    logic [W-1:0] err_count;
    logic [1:0] vec_idx;
    logic ffv;
    logic [1:0] ffvec;
    logic [3:0] tt_m;

    logic s_start;
    logic s_e;
    logic s_a;
    logic s_b;
    logic s_busy;
    logic s_done;
    logic s_pass;
    logic [SW-1:0] s_err;
    logic [1:0] s_vec;
    logic s_ffv;
    logic [1:0] s_ffvec;
    logic [3:0] tt_s;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        string      nm;
        logic [3:0] tt;
        int         err;
        bit         ffv;
        int         ffvec;
    } case_t;

    always #5 clk = ~clk;

    // Gate under test modelled as a truth table indexed by {a,b}.
    assign e_m = tt_m[{a, b}];
    assign s_e = tt_s[{s_a, s_b}];

    demorgan_stim_checker #(
        .HOLD_CYCLES(H), .PASSES(P), .ERR_W(W)
    ) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .e_in(e_m),
        .a(a), .b(b), .busy(busy), .done(done), .pass(pass),
        .err_count(err_count), .vec_idx(vec_idx),
        .first_fail_valid(ffv), .first_fail_vec(ffvec)
    );

    demorgan_stim_checker #(
        .HOLD_CYCLES(SH), .PASSES(P), .ERR_W(SW)
    ) u_sat (
        .clk(clk), .rst_n(rst_n), .start(s_start), .e_in(s_e),
        .a(s_a), .b(s_b), .busy(s_busy), .done(s_done), .pass(s_pass),
        .err_count(s_err), .vec_idx(s_vec),
        .first_fail_valid(s_ffv), .first_fail_vec(s_ffvec)
    );

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d", nm, act, exp);
        end
    endtask

    // Whole-run outcome from the truth table alone.
    task automatic model(input logic [3:0] t, input int w,
                         output int err, output bit fv, output int fvec);
        int per_pass;
        int total;
        int cap;
        logic [1:0] v;
        per_pass = 0;
        fv = 1'b0;
        fvec = 0;
        for (int i = NUM_VEC - 1; i >= 0; i--) begin
            v = 2'(i);
            if (t[i] != expected_e(v[1], v[0])) begin
                per_pass++;
                fv = 1'b1;
                fvec = i;
            end
        end
        total = per_pass * P;
        cap = (1 << w) - 1;
        err = (total > cap) ? cap : total;
    endtask

    task automatic run_main(input string nm, input logic [3:0] t,
                            input int pulse_at, input int e_err,
                            input bit e_fv, input int e_fvec);
        int cyc;
        bit seq_ok;
        logic [1:0] ev;
        tt_m = t;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        seq_ok = busy && !done && vec_idx == 2'd0 && !a && !b;
        cyc = 0;
        while (!done && cyc < 400) begin
            start = (cyc + 1 == pulse_at);
            @(posedge clk); #1;
            cyc++;
            if (!done) begin
                ev = 2'((cyc / (H + 1)) % NUM_VEC);
                if (vec_idx != ev || a != ev[1] || b != ev[0] || !busy)
                    seq_ok = 1'b0;
            end
        end
        start = 1'b0;
        chk({nm, ".latency"}, cyc, LAT);
        chk({nm, ".sweep"}, int'(seq_ok), 1);
        chk({nm, ".err"}, int'(err_count), e_err);
        chk({nm, ".ffv"}, int'(ffv), int'(e_fv));
        chk({nm, ".ffvec"}, int'(ffvec), e_fvec);
        chk({nm, ".pass"}, int'(pass), int'(e_err == 0));
        chk({nm, ".idle_out"}, int'({busy, vec_idx, a, b}), 0);
    endtask

    task automatic run_sat(input string nm, input logic [3:0] t);
        int cyc;
        int e_err;
        bit e_fv;
        int e_fvec;
        model(t, SW, e_err, e_fv, e_fvec);
        tt_s = t;
        s_start = 1'b1;
        @(posedge clk); #1;
        s_start = 1'b0;
        cyc = 0;
        while (!s_done && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk({nm, ".latency"}, cyc, SLAT);
        chk({nm, ".err"}, int'(s_err), e_err);
        chk({nm, ".ffv"}, int'(s_ffv), int'(e_fv));
        chk({nm, ".ffvec"}, int'(s_ffvec), e_fvec);
        chk({nm, ".pass"}, int'(s_pass), int'(e_err == 0));
    endtask

    initial begin
        case_t tbl[5];
        int e_err;
        bit e_fv;
        int e_fvec;
        int cyc;
        logic [3:0] t;

        tbl[0] = '{"golden",  4'b0001, 0, 1'b0, 0};
        tbl[1] = '{"nand",    4'b0111, 8, 1'b1, 1};
        tbl[2] = '{"stuck1",  4'b1111, 12, 1'b1, 1};
        tbl[3] = '{"stuck0",  4'b0000, 4, 1'b1, 0};
        tbl[4] = '{"xor",     4'b0110, 12, 1'b1, 0};

        rst_n = 1'b0;
        start = 1'b0;
        s_start = 1'b0;
        tt_m = 4'b0001;
        tt_s = 4'b0001;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("reset.ctl", int'({busy, done, pass, a, b}), 0);
        chk("reset.err", int'(err_count), 0);
        chk("reset.vec", int'({vec_idx, ffv, ffvec}), 0);

        foreach (tbl[i])
            run_main(tbl[i].nm, tbl[i].tt, -1, tbl[i].err,
                     tbl[i].ffv, tbl[i].ffvec);

        for (int i = 0; i < 6; i++) begin
            t = 4'($urandom);
            model(t, W, e_err, e_fv, e_fvec);
            run_main($sformatf("rand%0d", i), t, -1, e_err, e_fv, e_fvec);
        end

        run_sat("sat.stuck1", 4'b1111);
        run_sat("sat.nand", 4'b0111);
        for (int i = 0; i < 3; i++)
            run_sat($sformatf("sat.rand%0d", i), 4'($urandom));

        // Abort a faulty run at T0+40, after six vectors were sampled.
        tt_m = 4'b0111;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        chk("midrst.err_before", int'(err_count), 3);
        rst_n = 1'b0;
        #1;
        chk("midrst.ctl", int'({busy, done, pass, a, b}), 0);
        chk("midrst.state", int'({err_count, vec_idx, ffv, ffvec}), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_main("after_rst", 4'b0001, -1, 0, 1'b0, 0);

        run_main("busy_start", 4'b0001, 10, 0, 1'b0, 0);

        // Held start: one-cycle done, then an immediate second run.
        tt_m = 4'b0001;
        start = 1'b1;
        @(posedge clk); #1;
        cyc = 0;
        while (!done && cyc < 400) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("held.first", cyc, LAT);
        @(posedge clk); #1;
        chk("held.pulse", int'({done, busy}), 1);
        cyc = 1;
        while (!done && cyc < 400) begin
            @(posedge clk); #1;
            cyc++;
        end
        start = 1'b0;
        chk("held.second", cyc, LAT + 1);
        chk("held.pass", int'(pass), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
